// File: rtl/psum_channel_accumulator.sv
// Accumulates adder-tree kernel sums over input-channel tiles with per-add
// signed saturation, then drains one word per handshake to the output buffer.

module psum_lane_add #(
  parameter int FW = 16,
  parameter int AW = 20
) (
  input  logic [AW-1:0] acc_even,
  input  logic [AW-1:0] acc_odd,
  input  logic [FW-1:0] sum_even,
  input  logic [FW-1:0] sum_odd,
  output logic [AW-1:0] nxt_even,
  output logic [AW-1:0] nxt_odd
);
  // One guard bit is enough: a single add can overflow by at most one bit.
  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [FW-1:0] s);
    logic [AW:0] t;
    t = {a[AW-1], a} + {{(AW+1-FW){s[FW-1]}}, s};
    if (t[AW] != t[AW-1])
      sat_add = t[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    else
      sat_add = t[AW-1:0];
  endfunction

  assign nxt_even = sat_add(acc_even, sum_even);
  assign nxt_odd  = sat_add(acc_odd, sum_odd);
endmodule

module psum_channel_accumulator #(
  parameter int Tn                 = 4,
  parameter int FEATURE_WIDTH      = 16,
  parameter int ACC_WIDTH          = 20,
  parameter int KERNEL_SIZE_5_MODE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  tile_count,
  input  logic                        kn_size_mode,
  input  logic                        sum_valid,
  input  logic [Tn*FEATURE_WIDTH-1:0] sum_even,
  input  logic [Tn*FEATURE_WIDTH-1:0] sum_odd,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_WIDTH-1:0]        out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        drop_err
);
  localparam int FW = FEATURE_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int NW = 2 * Tn;
  localparam int IW = $clog2(NW + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                   state;
  logic [7:0]               tc, cnt;
  logic                     mode5;
  logic [IW-1:0]            idx, nidx, total;
  logic [Tn-1:0][AW-1:0]    acc_even, acc_odd, nxt_even, nxt_odd;
  logic [NW-1:0][AW-1:0]    words;
  logic [AW-1:0]            next_word;
  logic                     clr, add_e, last_strobe;

  assign clr         = (state == IDLE) && start;
  assign add_e       = (state == ACCUM) && sum_valid;
  assign last_strobe = add_e && (8'(cnt + 8'd1) == tc);
  assign total       = mode5 ? IW'(Tn) : IW'(NW);
  assign nidx        = idx + IW'(1);

  for (genvar i = 0; i < Tn; i++) begin : g_lane
    psum_lane_add #(.FW(FW), .AW(AW)) u_lane (
      .acc_even (acc_even[i]),
      .acc_odd  (acc_odd[i]),
      .sum_even (sum_even[i*FW +: FW]),
      .sum_odd  (sum_odd[i*FW +: FW]),
      .nxt_even (nxt_even[i]),
      .nxt_odd  (nxt_odd[i])
    );
    // Interleaved 3x3 drain order: even[i], odd[i].
    assign words[2*i]   = acc_even[i];
    assign words[2*i+1] = acc_odd[i];
  end

  always_comb begin
    next_word = '0;
    if (mode5) begin
      for (int j = 0; j < Tn; j++)
        if (nidx == IW'(j)) next_word = acc_even[j];
    end else begin
      for (int j = 0; j < NW; j++)
        if (nidx == IW'(j)) next_word = words[j];
    end
  end

  // Odd accumulators only move in 3x3 mode; in 5x5 mode sum_odd is don't-care.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_even <= '0;
      acc_odd  <= '0;
    end else if (add_e) begin
      acc_even <= nxt_even;
      if (!mode5) acc_odd <= nxt_odd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tc        <= 8'd1;
      cnt       <= '0;
      mode5     <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tc       <= (tile_count == 8'd0) ? 8'd1 : tile_count;
            mode5    <= (kn_size_mode == 1'(KERNEL_SIZE_5_MODE));
            cnt      <= '0;
            drop_err <= 1'b0;
            busy     <= 1'b1;
            state    <= ACCUM;
          end else if (sum_valid) begin
            drop_err <= 1'b1;
          end
        end
        ACCUM: begin
          if (add_e) cnt <= cnt + 8'd1;
          // Word 0 is even[0] in both modes, so it comes straight off the adder.
          if (last_strobe) begin
            state     <= DRAIN;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= nxt_even[0];
            out_last  <= (total == IW'(1));
          end
        end
        DRAIN: begin
          if (sum_valid) drop_err <= 1'b1;
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              idx      <= nidx;
              out_data <= next_word;
              out_last <= (nidx == total - IW'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_channel_accumulator.sv
// Directed bench: table of jobs with hand-computed drain words, plus
// sequences for reset, backpressure, abort, ignored start and dropped strobes.

module tb_psum_channel_accumulator;
  localparam int TN = 4, FW = 16, AW = 20;

  logic              clk, rst, start, kn_size_mode, sum_valid, out_ready;
  logic [7:0]        tile_count;
  logic [TN*FW-1:0]  sum_even, sum_odd;
  logic              out_valid, out_last, busy, done, drop_err;
  logic [AW-1:0]     out_data;

  psum_channel_accumulator #(.Tn(TN), .FEATURE_WIDTH(FW), .ACC_WIDTH(AW),
                             .KERNEL_SIZE_5_MODE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_count(tile_count),
    .kn_size_mode(kn_size_mode), .sum_valid(sum_valid), .sum_even(sum_even),
    .sum_odd(sum_odd), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
    .drop_err(drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         mode;
    int           tile;
    int           nstr;
    logic [63:0]  ev;
    logic [63:0]  od;
    int           nw;
    logic [159:0] ex;
  } vec_t;

  vec_t        vt[5];
  int          n_pass = 0, n_tot = 0;
  logic [15:0] rdy_pat = 16'hFFB4;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] pk4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [159:0] pk8(input int w0, input int w1, input int w2, input int w3,
                                       input int w4, input int w5, input int w6, input int w7);
    return {20'(w7), 20'(w6), 20'(w5), 20'(w4), 20'(w3), 20'(w2), 20'(w1), 20'(w0)};
  endfunction

  task automatic set_vec(input int i, input logic m, input int t, input int ns,
                         input logic [63:0] e, input logic [63:0] o, input int n,
                         input logic [159:0] x);
    vt[i].mode = m; vt[i].tile = t; vt[i].nstr = ns;
    vt[i].ev = e; vt[i].od = o; vt[i].nw = n; vt[i].ex = x;
  endtask

  task automatic start_job(input int v);
    kn_size_mode = vt[v].mode;
    tile_count   = 8'(vt[v].tile);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("drop_err_cleared", int'(drop_err), 0);
  endtask

  task automatic strobe(input int v);
    sum_valid = 1'b1;
    sum_even  = vt[v].ev;
    sum_odd   = vt[v].od;
    tick;
    sum_valid = 1'b0;
    sum_even  = '0;
    sum_odd   = '0;
  endtask

  task automatic drain(input int v, input bit bp);
    int k, cyc, exp;
    logic [AW-1:0] held;
    logic held_last;
    bit hold;
    k = 0; cyc = 0; hold = 0; held = '0; held_last = 1'b0;
    while (k < vt[v].nw && cyc < 60) begin
      chk("out_valid_in_drain", int'(out_valid), 1);
      if (hold) begin
        chk("held_data", int'($signed(out_data)), int'($signed(held)));
        chk("held_last", int'(out_last), int'(held_last));
      end
      out_ready = bp ? rdy_pat[cyc % 16] : 1'b1;
      if (out_ready) begin
        exp = int'($signed(vt[v].ex[k*AW +: AW]));
        chk($sformatf("vec%0d_word%0d", v, k), int'($signed(out_data)), exp);
        chk($sformatf("vec%0d_last%0d", v, k), int'(out_last), int'(k == vt[v].nw - 1));
        k++;
        hold = 0;
      end else begin
        hold = 1;
        held = out_data;
        held_last = out_last;
      end
      tick;
      cyc++;
    end
    out_ready = 1'b1;
    chk("transfers", k, vt[v].nw);
    if (!bp) chk("drain_cycles", cyc, vt[v].nw);
    chk("done_pulse", int'(done), 1);
    chk("busy_after_drain", int'(busy), 0);
    chk("valid_after_drain", int'(out_valid), 0);
  endtask

  task automatic run_job(input int v, input bit bp);
    start_job(v);
    for (int s = 0; s < vt[v].nstr; s++) strobe(v);
    drain(v, bp);
  endtask

  initial begin
    set_vec(0, 1'b1, 3, 3, pk4(1, 2, 3, 4), '0, 4, pk8(3, 6, 9, 12, 0, 0, 0, 0));
    set_vec(1, 1'b0, 0, 1, pk4(10, 20, 30, 40), pk4(-1, -2, -3, -4), 8,
            pk8(10, -1, 20, -2, 30, -3, 40, -4));
    set_vec(2, 1'b1, 20, 20, pk4(32767, 1, -1, 5), '0, 4, pk8(524287, 20, -20, 100, 0, 0, 0, 0));
    set_vec(3, 1'b1, 20, 20, pk4(-32768, 2, -3, 100), '0, 4,
            pk8(-524288, 40, -60, 2000, 0, 0, 0, 0));
    set_vec(4, 1'b0, 2, 2, pk4(100, -200, 300, -400), pk4(7, 8, 9, 10), 8,
            pk8(200, 14, -400, 16, 600, 18, -800, 20));

    // Reset with random inputs
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      start = 1'($urandom); sum_valid = 1'($urandom); out_ready = 1'($urandom);
      kn_size_mode = 1'($urandom); tile_count = 8'($urandom);
      sum_even = {$urandom, $urandom}; sum_odd = {$urandom, $urandom};
      tick;
    end
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_drop_err", int'(drop_err), 0);
    rst = 1'b0; start = 1'b0; sum_valid = 1'b0; out_ready = 1'b1;
    sum_even = '0; sum_odd = '0;
    tick;
    chk("idle_busy", int'(busy), 0);
    sum_valid = 1'b1;
    tick;
    sum_valid = 1'b0;
    chk("idle_strobe_drop_err", int'(drop_err), 1);
    chk("idle_strobe_busy", int'(busy), 0);

    for (int v = 0; v < 5; v++) run_job(v, 1'b0);

    // Backpressure on the 3x3 job
    run_job(1, 1'b1);

    // start during ACCUM must not restart the count
    start_job(0);
    strobe(0);
    kn_size_mode = 1'b0; tile_count = 8'd1; start = 1'b1;
    tick;
    start = 1'b0;
    chk("ign_start_busy", int'(busy), 1);
    strobe(0);
    chk("ign_start_no_drain", int'(out_valid), 0);
    strobe(0);
    drain(0, 1'b0);

    // sum_valid during DRAIN: flagged, values untouched
    start_job(4);
    strobe(4);
    strobe(4);
    out_ready = 1'b0;
    sum_valid = 1'b1; sum_even = pk4(1000, 1000, 1000, 1000); sum_odd = pk4(1000, 1000, 1000, 1000);
    tick;
    sum_valid = 1'b0; sum_even = '0; sum_odd = '0;
    chk("drain_drop_err", int'(drop_err), 1);
    chk("drain_drop_word0", int'($signed(out_data)), 200);
    drain(4, 1'b0);
    chk("drop_err_sticky", int'(drop_err), 1);

    // Reset after the third drain word, then a fresh job
    start_job(1);
    strobe(1);
    out_ready = 1'b1;
    tick; tick; tick;
    chk("pre_abort_valid", int'(out_valid), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    run_job(1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
